// File: rtl/regfile_writeback.sv
// Register-file write-back: four sources share one write port (load > ext > exe > mov),
// with a FIFO scoreboard of outstanding load destinations that blocks WAW hazards.
module regfile_writeback #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int ZERO_REG = 1,
  parameter  int LD_DEPTH = 4,
  localparam int AW       = $clog2(NREG),
  localparam int AW_LD    = $clog2(LD_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exe_valid,
  output logic                 exe_ready,
  input  logic [AW-1:0]        exe_addr,
  input  logic [XLEN-1:0]      exe_data,
  input  logic                 mov_valid,
  output logic                 mov_ready,
  input  logic [AW-1:0]        mov_addr,
  input  logic [XLEN-1:0]      mov_data,
  input  logic                 ext_valid,
  output logic                 ext_ready,
  input  logic [AW-1:0]        ext_addr,
  input  logic [XLEN-1:0]      ext_data,
  input  logic                 ld_issue_valid,
  output logic                 ld_issue_ready,
  input  logic [AW-1:0]        ld_issue_addr,
  input  logic                 ld_done_valid,
  input  logic [XLEN-1:0]      ld_done_data,
  output logic [NREG*XLEN-1:0] regs,
  output logic [NREG-1:0]      busy,
  output logic [AW_LD:0]       ld_pending,
  output logic                 wb_done,
  output logic [AW-1:0]        wb_done_addr,
  output logic                 err_ld_underflow
);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [AW-1:0]       fifo_q [LD_DEPTH];
  logic [AW-1:0]       fifo_d [LD_DEPTH];
  logic [LD_DEPTH-1:0] fvld_q, fvld_d;
  logic [AW_LD:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                wb_done_q, wb_done_d;
  logic [AW-1:0]       wb_done_addr_q, wb_done_addr_d;
  logic                err_q, err_d;

  logic                fifo_empty, fifo_full, ld_pop, ld_push;
  logic [AW_LD-1:0]    wr_idx, rd_idx;
  logic [AW-1:0]       head_addr;
  logic [NREG-1:0]     busy_w;
  logic                ext_acc, exe_acc, mov_acc;
  logic                commit;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;

  assign wr_idx     = wr_ptr_q[AW_LD-1:0];
  assign rd_idx     = rd_ptr_q[AW_LD-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr_q[AW_LD] != rd_ptr_q[AW_LD]);
  assign head_addr  = fifo_q[rd_idx];

  assign ld_pop  = ld_done_valid && !fifo_empty;
  // Readiness is based on the registered full flag: a same-cycle pop never frees a slot.
  assign ld_push = ld_issue_valid && !fifo_full;

  always_comb begin
    busy_w = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (fvld_q[i]) busy_w[fifo_q[i]] = 1'b1;
    end
    if (ZERO_REG != 0) busy_w[0] = 1'b0;
  end

  assign ext_ready = !ld_pop && !busy_w[ext_addr];
  assign exe_ready = !ld_pop && !busy_w[exe_addr] && !ext_valid;
  assign mov_ready = !ld_pop && !busy_w[mov_addr] && !ext_valid && !exe_valid;
  assign ld_issue_ready = !fifo_full;

  assign ext_acc = ext_valid && ext_ready;
  assign exe_acc = exe_valid && exe_ready;
  assign mov_acc = mov_valid && mov_ready;

  always_comb begin
    commit  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (ld_pop) begin
      commit  = 1'b1;
      wr_addr = head_addr;
      wr_data = ld_done_data;
    end else if (ext_acc) begin
      commit  = 1'b1;
      wr_addr = ext_addr;
      wr_data = ext_data;
    end else if (exe_acc) begin
      commit  = 1'b1;
      wr_addr = exe_addr;
      wr_data = exe_data;
    end else if (mov_acc) begin
      commit  = 1'b1;
      wr_addr = mov_addr;
      wr_data = mov_data;
    end
  end

  always_comb begin
    regs_d = regs_q;
    // Register 0 of a hardwired-zero file is never stored, so it reads 0 forever.
    if (commit && !((ZERO_REG != 0) && (wr_addr == '0))) regs_d[wr_addr] = wr_data;

    fifo_d   = fifo_q;
    fvld_d   = fvld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ld_pop) begin
      fvld_d[rd_idx] = 1'b0;
      rd_ptr_d       = rd_ptr_q + 1'b1;
    end
    if (ld_push) begin
      fifo_d[wr_idx] = ld_issue_addr;
      fvld_d[wr_idx] = 1'b1;
      wr_ptr_d       = wr_ptr_q + 1'b1;
    end

    wb_done_d      = commit;
    wb_done_addr_d = commit ? wr_addr : wb_done_addr_q;
    err_d          = err_q || (ld_done_valid && fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      for (int i = 0; i < LD_DEPTH; i++) fifo_q[i] <= '0;
      fvld_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wb_done_q      <= 1'b0;
      wb_done_addr_q <= '0;
      err_q          <= 1'b0;
    end else begin
      regs_q         <= regs_d;
      fifo_q         <= fifo_d;
      fvld_q         <= fvld_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wb_done_q      <= wb_done_d;
      wb_done_addr_q <= wb_done_addr_d;
      err_q          <= err_d;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_regs
    assign regs[r*XLEN +: XLEN] = regs_q[r];
  end

  assign busy             = busy_w;
  assign ld_pending       = wr_ptr_q - rd_ptr_q;
  assign wb_done          = wb_done_q;
  assign wb_done_addr     = wb_done_addr_q;
  assign err_ld_underflow = err_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a GPR instance (ZERO_REG=1) and an FPR instance
// (ZERO_REG=0) share the same stimulus; expected values are hand-computed.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid, mov_valid, ext_valid, ld_issue_valid, ld_done_valid;
  logic [4:0]  exe_addr, mov_addr, ext_addr, ld_issue_addr;
  logic [31:0] exe_data, mov_data, ext_data, ld_done_data;

  logic          exe_ready, mov_ready, ext_ready, ld_issue_ready;
  logic [1023:0] regs;
  logic [31:0]   busy;
  logic [2:0]    ld_pending;
  logic          wb_done;
  logic [4:0]    wb_done_addr;
  logic          err_ld_underflow;

  logic          f_exe_ready, f_mov_ready, f_ext_ready, f_ld_issue_ready;
  logic [1023:0] f_regs;
  logic [31:0]   f_busy;
  logic [2:0]    f_ld_pending;
  logic          f_wb_done;
  logic [4:0]    f_wb_done_addr;
  logic          f_err_ld_underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_writeback #(.XLEN(32), .NREG(32), .ZERO_REG(1), .LD_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_addr(exe_addr), .exe_data(exe_data),
    .mov_valid(mov_valid), .mov_ready(mov_ready), .mov_addr(mov_addr), .mov_data(mov_data),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_addr(ext_addr), .ext_data(ext_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_issue_addr(ld_issue_addr),
    .ld_done_valid(ld_done_valid), .ld_done_data(ld_done_data),
    .regs(regs), .busy(busy), .ld_pending(ld_pending), .wb_done(wb_done),
    .wb_done_addr(wb_done_addr), .err_ld_underflow(err_ld_underflow)
  );

  regfile_writeback #(.XLEN(32), .NREG(32), .ZERO_REG(0), .LD_DEPTH(4)) dut_fpr (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_ready(f_exe_ready), .exe_addr(exe_addr), .exe_data(exe_data),
    .mov_valid(mov_valid), .mov_ready(f_mov_ready), .mov_addr(mov_addr), .mov_data(mov_data),
    .ext_valid(ext_valid), .ext_ready(f_ext_ready), .ext_addr(ext_addr), .ext_data(ext_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(f_ld_issue_ready), .ld_issue_addr(ld_issue_addr),
    .ld_done_valid(ld_done_valid), .ld_done_data(ld_done_data),
    .regs(f_regs), .busy(f_busy), .ld_pending(f_ld_pending), .wb_done(f_wb_done),
    .wb_done_addr(f_wb_done_addr), .err_ld_underflow(f_err_ld_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gpr(input int r);
    return regs[r*32 +: 32];
  endfunction

  function automatic logic [31:0] fpr(input int r);
    return f_regs[r*32 +: 32];
  endfunction

  // Inputs change 1 time unit after the rising edge; checks follow after another unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    exe_valid = 0; mov_valid = 0; ext_valid = 0; ld_issue_valid = 0; ld_done_valid = 0;
    exe_addr = 0; mov_addr = 0; ext_addr = 0; ld_issue_addr = 0;
    exe_data = 0; mov_data = 0; ext_data = 0; ld_done_data = 0;
    #12;
    chk("rst_regs_zero", {31'd0, regs == '0}, 32'd1);
    chk("rst_busy", busy, 32'd0);
    chk("rst_pending", {29'd0, ld_pending}, 32'd0);
    chk("rst_wb_done", {31'd0, wb_done}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_done_addr}, 32'd0);
    chk("rst_err", {31'd0, err_ld_underflow}, 32'd0);
    chk("rst_issue_rdy", {31'd0, ld_issue_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // Priority: ext > exe > mov, one commit per edge
    ext_valid = 1; ext_addr = 5; ext_data = 32'h11;
    exe_valid = 1; exe_addr = 6; exe_data = 32'h22;
    mov_valid = 1; mov_addr = 7; mov_data = 32'h33;
    #1;
    chk("pri_ext_rdy", {31'd0, ext_ready}, 32'd1);
    chk("pri_exe_rdy", {31'd0, exe_ready}, 32'd0);
    chk("pri_mov_rdy", {31'd0, mov_ready}, 32'd0);
    tick(); ext_valid = 0; #1;
    chk("pri_r5", gpr(5), 32'h11);
    chk("pri_done1", {31'd0, wb_done}, 32'd1);
    chk("pri_addr1", {27'd0, wb_done_addr}, 32'd5);
    chk("pri_exe_rdy2", {31'd0, exe_ready}, 32'd1);
    chk("pri_mov_rdy2", {31'd0, mov_ready}, 32'd0);
    tick(); exe_valid = 0; #1;
    chk("pri_r6", gpr(6), 32'h22);
    chk("pri_done2", {31'd0, wb_done}, 32'd1);
    chk("pri_addr2", {27'd0, wb_done_addr}, 32'd6);
    chk("pri_r7_pending", gpr(7), 32'h0);
    tick(); mov_valid = 0; #1;
    chk("pri_r7", gpr(7), 32'h33);
    chk("pri_done3", {31'd0, wb_done}, 32'd1);
    chk("pri_addr3", {27'd0, wb_done_addr}, 32'd7);
    tick(); #1;
    chk("pri_done_off", {31'd0, wb_done}, 32'd0);

    // Two loads to r3 block an exe write to r3 until both complete
    ld_issue_valid = 1; ld_issue_addr = 3;
    tick(); tick(); ld_issue_valid = 0; #1;
    chk("ld_pending2", {29'd0, ld_pending}, 32'd2);
    chk("ld_busy3", {31'd0, busy[3]}, 32'd1);
    exe_valid = 1; exe_addr = 3; exe_data = 32'h77;
    #1;
    chk("ld_exe_blk0", {31'd0, exe_ready}, 32'd0);
    ld_done_valid = 1; ld_done_data = 32'hA;
    #1;
    chk("ld_exe_blk1", {31'd0, exe_ready}, 32'd0);
    tick(); ld_done_data = 32'hB; #1;
    chk("ld_r3_a", gpr(3), 32'hA);
    chk("ld_busy3_still", {31'd0, busy[3]}, 32'd1);
    chk("ld_pending1", {29'd0, ld_pending}, 32'd1);
    chk("ld_exe_blk2", {31'd0, exe_ready}, 32'd0);
    tick(); ld_done_valid = 0; #1;
    chk("ld_r3_b", gpr(3), 32'hB);
    chk("ld_busy3_clr", {31'd0, busy[3]}, 32'd0);
    chk("ld_pending0", {29'd0, ld_pending}, 32'd0);
    chk("ld_done_addr", {27'd0, wb_done_addr}, 32'd3);
    chk("ld_exe_free", {31'd0, exe_ready}, 32'd1);
    tick(); exe_valid = 0; #1;
    chk("ld_r3_exe", gpr(3), 32'h77);

    // FIFO full; issue refused in a popping cycle, accepted next
    ld_issue_valid = 1;
    ld_issue_addr = 1; tick();
    ld_issue_addr = 2; tick();
    ld_issue_addr = 8; tick();
    ld_issue_addr = 9; tick();
    ld_issue_addr = 10; #1;
    chk("full_rdy", {31'd0, ld_issue_ready}, 32'd0);
    chk("full_pending", {29'd0, ld_pending}, 32'd4);
    chk("full_busy", busy, 32'h0000_0306);
    ld_done_valid = 1; ld_done_data = 32'h100;
    #1;
    chk("full_rdy_pop", {31'd0, ld_issue_ready}, 32'd0);
    tick(); ld_done_valid = 0; #1;
    chk("full_pending3", {29'd0, ld_pending}, 32'd3);
    chk("full_r1", gpr(1), 32'h100);
    chk("full_rdy_next", {31'd0, ld_issue_ready}, 32'd1);
    tick(); ld_issue_valid = 0; #1;
    chk("full_pending4b", {29'd0, ld_pending}, 32'd4);
    ld_done_valid = 1; ld_done_data = 32'h200; tick();
    ld_done_data = 32'h300; tick();
    ld_done_valid = 0; #1;
    chk("drain_pending2", {29'd0, ld_pending}, 32'd2);
    chk("drain_r2", gpr(2), 32'h200);
    chk("drain_r8", gpr(8), 32'h300);
    // Head is r9; issue another load to r9 while it completes
    ld_issue_valid = 1; ld_issue_addr = 9;
    ld_done_valid = 1; ld_done_data = 32'h400;
    #1;
    chk("pp_issue_rdy", {31'd0, ld_issue_ready}, 32'd1);
    tick(); ld_issue_valid = 0; ld_done_valid = 0; #1;
    chk("pp_pending2", {29'd0, ld_pending}, 32'd2);
    chk("pp_r9", gpr(9), 32'h400);
    chk("pp_busy9", {31'd0, busy[9]}, 32'd1);
    ld_done_valid = 1; ld_done_data = 32'h500; tick();
    ld_done_data = 32'h600; tick();
    ld_done_valid = 0; #1;
    chk("pp_r10", gpr(10), 32'h500);
    chk("pp_r9b", gpr(9), 32'h600);
    chk("pp_busy_clr", busy, 32'd0);
    chk("pp_pending0", {29'd0, ld_pending}, 32'd0);

    // Zero register
    exe_valid = 1; exe_addr = 0; exe_data = 32'hFFFF_FFFF;
    #1;
    chk("z_exe_rdy", {31'd0, exe_ready}, 32'd1);
    tick(); exe_valid = 0; #1;
    chk("z_gpr_r0", gpr(0), 32'h0);
    chk("z_done", {31'd0, wb_done}, 32'd1);
    chk("z_addr", {27'd0, wb_done_addr}, 32'd0);
    chk("z_fpr_r0", fpr(0), 32'hFFFF_FFFF);

    // Load completion beats ext
    ld_issue_valid = 1; ld_issue_addr = 4;
    tick(); ld_issue_valid = 0;
    ld_done_valid = 1; ld_done_data = 32'h44;
    ext_valid = 1; ext_addr = 12; ext_data = 32'hCC;
    #1;
    chk("lx_ext_blk", {31'd0, ext_ready}, 32'd0);
    tick(); ld_done_valid = 0; #1;
    chk("lx_r4", gpr(4), 32'h44);
    chk("lx_addr4", {27'd0, wb_done_addr}, 32'd4);
    chk("lx_r12_wait", gpr(12), 32'h0);
    chk("lx_ext_rdy", {31'd0, ext_ready}, 32'd1);
    tick(); ext_valid = 0; #1;
    chk("lx_r12", gpr(12), 32'hCC);
    chk("lx_addr12", {27'd0, wb_done_addr}, 32'd12);

    // Reset mid-flight, then underflow
    ld_issue_valid = 1; ld_issue_addr = 13; tick();
    ld_issue_addr = 14; tick();
    ld_issue_valid = 0; #1;
    chk("rf_pending2", {29'd0, ld_pending}, 32'd2);
    chk("rf_err0", {31'd0, err_ld_underflow}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rf_busy", busy, 32'd0);
    chk("rf_pending", {29'd0, ld_pending}, 32'd0);
    chk("rf_regs_zero", {31'd0, regs == '0}, 32'd1);
    tick(); rst = 1'b0;
    ld_done_valid = 1; ld_done_data = 32'hDEAD;
    tick(); ld_done_valid = 0; #1;
    chk("uf_err", {31'd0, err_ld_underflow}, 32'd1);
    chk("uf_no_done", {31'd0, wb_done}, 32'd0);
    chk("uf_regs_zero", {31'd0, regs == '0}, 32'd1);
    chk("uf_pending", {29'd0, ld_pending}, 32'd0);
    tick(); tick(); #1;
    chk("uf_err_sticky", {31'd0, err_ld_underflow}, 32'd1);
    rst = 1'b1;
    #1;
    chk("uf_err_clr", {31'd0, err_ld_underflow}, 32'd0);
    tick(); rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
